bcd_countdown_timer: RTL
========================

# bcd_countdown_timer

Parametrised multi-digit BCD countdown timer for the math-game datapath. It generalises the per-digit timer cells into one block: N cascaded BCD digits with borrow propagation, explicit run/pause/expire control, a saturating BCD bonus-time add, and an optional auto-reload mode. It sits between the 1 Hz tick generator and the seven-segment display driver, and reports expiry to the game controller.

## Interface
- NUM_DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- RESET_VALUE, all digits 9 (8'h99 at default width), count value after reset; width 4*NUM_DIGITS.
- AUTO_RELOAD, 0, when 1 the timer reloads `reload_reg` on expiry instead of stopping.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- load  in  1  capture `load_value` into count and `reload_reg`; go to IDLE.
- load_value  in  4*NUM_DIGITS  BCD preset; any nibble >9 is clamped to 9.
- start  in  1  IDLE/PAUSED -> RUNNING.
- pause  in  1  RUNNING -> PAUSED.
- tick  in  1  one-cycle count enable (1 s strobe).
- bonus  in  1  add `bonus_value` to count.
- bonus_value  in  4*NUM_DIGITS  BCD addend; nibbles >9 clamped to 9.
- digits  out  4*NUM_DIGITS  current count, BCD.
- running  out  1  high in RUNNING.
- expired  out  1  high in EXPIRED.
- timeout_pulse  out  1  one-cycle strobe on each expiry event.

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED (2-bit encoded).
- Reset values: digits=RESET_VALUE, reload_reg=RESET_VALUE, state=IDLE, running=0, expired=0, timeout_pulse=0.
- Priority per cycle: reset > load > start/pause > bonus/tick.
- load: any state -> IDLE; count and reload_reg <= clamped load_value. Same-cycle start, pause, bonus, and tick are ignored.
- start: from IDLE or PAUSED -> RUNNING. Ignored in RUNNING and EXPIRED. If count is 0 at start, go directly to EXPIRED and raise timeout_pulse.
- pause: RUNNING -> PAUSED; ignored otherwise. pause and start both high: pause wins in RUNNING, start wins in PAUSED.
- tick: decrements only in RUNNING (not on the cycle start is accepted). BCD decrement: digit i is 0 with borrow -> 9 and borrow propagates; otherwise digit-1 and borrow stops.
- Expiry: tick in RUNNING that takes count to 0 -> state EXPIRED, count 0, timeout_pulse=1 for that cycle. With AUTO_RELOAD=1: count <= reload_reg, state stays RUNNING, timeout_pulse=1. If reload_reg is 0, go to EXPIRED.
- bonus: honoured in IDLE, RUNNING, PAUSED; ignored in EXPIRED. Per-digit BCD add with carry; on carry-out of the top digit, saturate every digit to 9.
- bonus and tick together in RUNNING: result = saturate(count+bonus) - 1. Never expires, since the sum is >= 1 whenever bonus_value is nonzero. With bonus_value 0 it behaves as a plain tick.
- EXPIRED is left only by load or reset.

## Timing
- All outputs are registered and update on the clk edge that samples the control input; latency 1 cycle.
- timeout_pulse is high exactly one cycle per expiry event, the cycle after the expiring tick edge.
- running/expired change on the same edge as the state.
- Reset mid-count: next edge returns everything to reset values, regardless of other inputs.
- Back-to-back ticks (tick held high) decrement every cycle; the block does not require tick to be a strobe.

## Test plan
- Reset, NUM_DIGITS=2: assert reset 1 cycle -> digits=0x99, state IDLE, all flags 0. Ticks in IDLE leave 0x99.
- Load 0x45, start, then 45 ticks -> digits walk 0x45, 0x44..0x40, 0x39..0x01, 0x00. timeout_pulse high 1 cycle, expired=1. Further ticks/start leave 0x00.
- Borrow chain, NUM_DIGITS=4: load 0x1000, start, 1 tick -> 0x0999. Load 0x5A3F -> digits=0x5939.
- Pause: running at 0x30, pause, 5 ticks -> still 0x30. start, 1 tick -> 0x29. start+pause same cycle in RUNNING -> PAUSED.
- Bonus: count 0x95, bonus 0x10 -> 0x99 (saturate). Count 0x07, bonus 0x05 with tick same cycle -> 0x11. Bonus in EXPIRED -> stays 0x00.
- AUTO_RELOAD=1: load 0x03, start, 3 ticks -> 0x00 never shown; count returns to 0x03, running stays 1, timeout_pulse 1 cycle. Repeats each 3 ticks.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: N-digit BCD countdown with run/pause/expire control,
// saturating BCD bonus add and optional auto-reload on expiry.
// Ports: clk, reset (sync, active-high); load/load_value preset;
//   start, pause run control; tick count enable; bonus/bonus_value addend;
//   digits (BCD count), running, expired, timeout_pulse (registered outputs).
module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0] RESET_VALUE = {NUM_DIGITS{4'h9}},
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  input  logic                    bonus,
  input  logic [4*NUM_DIGITS-1:0] bonus_value,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    expired,
  output logic                    timeout_pulse
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_count;
  logic [W-1:0]   r_reload;
  logic           r_running;
  logic           r_expired;
  logic           r_pulse;

  logic [W-1:0]   w_load;
  logic [W-1:0]   w_badd;
  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_dec;
  logic           w_cnt_zero;
  logic           w_dec_zero;
  logic           w_reload_ok;

  function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      f[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return f;
  endfunction

  // Borrow enters digit 0; a zero digit wraps to 9 and passes it on.
  function automatic logic [W-1:0] f_dec(input logic [W-1:0] v);
    logic [W-1:0] f;
    logic         b;
    f = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          f[4*i +: 4] = 4'd9;
        end else begin
          f[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return f;
  endfunction

  // Carry out of the top digit saturates the whole count to all 9s.
  function automatic logic [W-1:0] f_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] f;
    logic [4:0]   s;
    logic         c;
    f = '0;
    c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      f[4*i +: 4] = s[3:0];
    end
    if (c) f = {NUM_DIGITS{4'h9}};
    return f;
  endfunction

  assign w_load      = f_clamp(load_value);
  assign w_badd      = f_clamp(bonus_value);
  assign w_sum       = bonus ? f_add(r_count, w_badd) : r_count;
  assign w_dec       = f_dec(w_sum);
  assign w_cnt_zero  = (r_count == '0);
  assign w_dec_zero  = (w_dec == '0);
  assign w_reload_ok = AUTO_RELOAD && (r_reload != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= RESET_VALUE;
      r_reload  <= RESET_VALUE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else if (load) begin
      r_state   <= S_IDLE;
      r_count   <= w_load;
      r_reload  <= w_load;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        S_IDLE, S_PAUSED: begin
          if (start) begin
            if (w_cnt_zero) begin
              r_state   <= S_EXPIRED;
              r_running <= 1'b0;
              r_expired <= 1'b1;
              r_pulse   <= 1'b1;
            end else begin
              r_state   <= S_RUNNING;
              r_running <= 1'b1;
            end
          end else if (bonus) begin
            r_count <= w_sum;
          end
        end
        S_RUNNING: begin
          if (pause) begin
            r_state   <= S_PAUSED;
            r_running <= 1'b0;
          end else if (tick) begin
            if (w_dec_zero) begin
              r_pulse <= 1'b1;
              if (w_reload_ok) begin
                r_count <= r_reload;
              end else begin
                r_count   <= '0;
                r_state   <= S_EXPIRED;
                r_running <= 1'b0;
                r_expired <= 1'b1;
              end
            end else begin
              r_count <= w_dec;
            end
          end else if (bonus) begin
            r_count <= w_sum;
          end
        end
        S_EXPIRED: begin
          r_state <= S_EXPIRED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign digits        = r_count;
  assign running       = r_running;
  assign expired       = r_expired;
  assign timeout_pulse = r_pulse;

endmodule
